// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: per-cycle stage enables/bubbles, fetch redirect, debug stall/flush counters.
// Latency: zero-cycle combinational decision; state/counters update on stage_clk rising edge.
module pipeline_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  stage_clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic [31:0]           ex_target,
    input  logic                  imem_ready,
    output logic                  take_new_pc,
    output logic [31:0]           pc_new,
    output logic                  if_ena,
    output logic                  id_ena,
    output logic                  ex_ena,
    output logic                  mem_ena,
    output logic                  wb_ena,
    output logic                  if_x,
    output logic                  id_x,
    output logic                  ex_x,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_target;
    logic [31:0] pend_target_nxt;
    logic        load_use;
    logic        stall_evt;
    logic        flush_evt;

    // A load writing x0 never creates a real dependency.
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge stage_clk) begin
        if (!reset) begin
            state       <= RUN;
            pend_target <= 32'h0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        take_new_pc     = 1'b0;
        pc_new          = 32'h0;
        if_ena          = 1'b1;
        id_ena          = 1'b1;
        ex_ena          = 1'b1;
        mem_ena         = 1'b1;
        wb_ena          = 1'b1;
        if_x            = 1'b0;
        id_x            = 1'b0;
        ex_x            = 1'b0;
        stall_evt       = 1'b0;
        flush_evt       = 1'b0;

        if (!reset) begin
            state_nxt       = RUN;
            pend_target_nxt = 32'h0;
            if_ena          = 1'b0;
            id_ena          = 1'b0;
            ex_ena          = 1'b0;
            mem_ena         = 1'b0;
            wb_ena          = 1'b0;
            if_x            = 1'b1;
            id_x            = 1'b1;
            ex_x            = 1'b1;
        end else if (ex_redirect) begin
            if_x      = 1'b1;
            id_x      = 1'b1;
            flush_evt = 1'b1;
            if (imem_ready) begin
                take_new_pc = 1'b1;
                pc_new      = ex_target;
                state_nxt   = RUN;
            end else begin
                pend_target_nxt = ex_target;
                state_nxt       = REDIR_PEND;
            end
        end else if (state == REDIR_PEND) begin
            // Hold fetch until imem can accept the pending target; keep ID empty meanwhile.
            id_x = 1'b1;
            if (imem_ready) begin
                take_new_pc = 1'b1;
                pc_new      = pend_target;
                state_nxt   = RUN;
            end else begin
                if_ena = 1'b0;
            end
        end else if (load_use) begin
            if_ena    = 1'b0;
            id_ena    = 1'b0;
            ex_x      = 1'b1;
            stall_evt = 1'b1;
        end else if (!imem_ready) begin
            if_ena    = 1'b0;
            id_x      = 1'b1;
            stall_evt = 1'b1;
        end
    end

    always_ff @(posedge stage_clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_evt && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_ONE;
            if (flush_evt && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit with an expected-output scoreboard.
module tb_pipeline_control_unit;

    localparam int RW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic [8:0]    ctl;
        logic [31:0]   pc;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    // ctl = {take_new_pc, if_ena, id_ena, ex_ena, mem_ena, wb_ena, if_x, id_x, ex_x}
    localparam logic [8:0] C_RUN   = 9'b0_11111_000;
    localparam logic [8:0] C_RST   = 9'b0_00000_111;
    localparam logic [8:0] C_LU    = 9'b0_00111_001;
    localparam logic [8:0] C_RGO   = 9'b1_11111_110;
    localparam logic [8:0] C_RWAIT = 9'b0_11111_110;
    localparam logic [8:0] C_PWAIT = 9'b0_01111_010;
    localparam logic [8:0] C_PGO   = 9'b1_11111_010;
    localparam logic [8:0] C_IWAIT = 9'b0_01111_010;

    logic          stage_clk;
    logic          reset;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, imem_ready;
    logic [31:0]   ex_target;
    logic          take_new_pc;
    logic [31:0]   pc_new;
    logic          if_ena, id_ena, ex_ena, mem_ena, wb_ena, if_x, id_x, ex_x;
    logic [CW-1:0] stall_count, flush_count;

    int   tests;
    int   fails;
    exp_t sb[$];

    pipeline_control_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .stage_clk   (stage_clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .imem_ready  (imem_ready),
        .take_new_pc (take_new_pc),
        .pc_new      (pc_new),
        .if_ena      (if_ena),
        .id_ena      (id_ena),
        .ex_ena      (ex_ena),
        .mem_ena     (mem_ena),
        .wb_ena      (wb_ena),
        .if_x        (if_x),
        .id_x        (id_x),
        .ex_x        (ex_x),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial begin
        stage_clk = 1'b0;
        forever #5 stage_clk = ~stage_clk;
    end

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = '0; ex_redirect = 1'b0; ex_target = 32'h0;
        imem_ready = 1'b1;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        logic [8:0] obs_ctl;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed outputs unchecked", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            obs_ctl = {take_new_pc, if_ena, id_ena, ex_ena, mem_ena, wb_ena, if_x, id_x, ex_x};
            tests++;
            assert (obs_ctl === e.ctl) else begin
                fails++;
                $error("FAIL %s ctl: observed %b expected %b", tag, obs_ctl, e.ctl);
            end
            tests++;
            assert (pc_new === e.pc) else begin
                fails++;
                $error("FAIL %s pc_new: observed %h expected %h", tag, pc_new, e.pc);
            end
            tests++;
            assert (stall_count === e.stall) else begin
                fails++;
                $error("FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, e.stall);
            end
            tests++;
            assert (flush_count === e.flush) else begin
                fails++;
                $error("FAIL %s flush_count: observed %0d expected %0d", tag, flush_count, e.flush);
            end
        end
    endtask

    // Push expectation for the inputs just driven, compare mid-cycle, then advance one edge.
    task automatic step(input string tag, input logic [8:0] ctl, input logic [31:0] pc,
                        input int st, input int fl);
        exp_t e;
        e.ctl = ctl; e.pc = pc; e.stall = CW'(st); e.flush = CW'(fl);
        sb.push_back(e);
        #2;
        check_out(tag);
        @(posedge stage_clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge stage_clk);
        #1;
        step("reset_hold", C_RST, 32'h0, 0, 0);
        reset = 1'b1;
        step("idle", C_RUN, 32'h0, 0, 0);

        // load-use through rs2, then no hazard once the load leaves EX
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        step("lu_rs2", C_LU, 32'h0, 0, 0);
        idle_inputs();
        step("lu_after", C_RUN, 32'h0, 1, 0);
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        step("lu_x0", C_RUN, 32'h0, 1, 0);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        step("lu_unused", C_RUN, 32'h0, 1, 0);
        id_uses_rs1 = 1'b1;
        step("lu_rs1", C_LU, 32'h0, 1, 0);
        idle_inputs();
        step("lu_rs1_after", C_RUN, 32'h0, 2, 0);

        ex_redirect = 1'b1; ex_target = 32'h0000_0100;
        step("redir_now", C_RGO, 32'h100, 2, 0);
        idle_inputs();
        step("redir_now_after", C_RUN, 32'h0, 2, 1);

        // redirect while imem is busy for 3 cycles
        ex_redirect = 1'b1; ex_target = 32'h0000_0200; imem_ready = 1'b0;
        step("redir_wait", C_RWAIT, 32'h0, 2, 1);
        ex_redirect = 1'b0; ex_target = 32'h0;
        step("pend_wait1", C_PWAIT, 32'h0, 2, 2);
        step("pend_wait2", C_PWAIT, 32'h0, 2, 2);
        imem_ready = 1'b1;
        step("pend_go", C_PGO, 32'h200, 2, 2);
        step("pend_done", C_RUN, 32'h0, 2, 2);

        ex_redirect = 1'b1; ex_target = 32'h0000_0300;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        step("redir_vs_lu", C_RGO, 32'h300, 2, 2);
        idle_inputs();
        step("redir_vs_lu_after", C_RUN, 32'h0, 2, 3);

        // a second redirect during REDIR_PEND replaces the pending target
        ex_redirect = 1'b1; ex_target = 32'h0000_0400; imem_ready = 1'b0;
        step("ovr_first", C_RWAIT, 32'h0, 2, 3);
        ex_target = 32'h0000_0500;
        step("ovr_second", C_RWAIT, 32'h0, 2, 4);
        ex_redirect = 1'b0; ex_target = 32'h0; imem_ready = 1'b1;
        step("ovr_go", C_PGO, 32'h500, 2, 5);
        step("ovr_done", C_RUN, 32'h0, 2, 5);

        // reset while pending drops the target
        ex_redirect = 1'b1; ex_target = 32'h0000_0600; imem_ready = 1'b0;
        step("rp_redir", C_RWAIT, 32'h0, 2, 5);
        idle_inputs();
        reset = 1'b0;
        step("rp_reset", C_RST, 32'h0, 2, 6);
        reset = 1'b1;
        step("rp_release", C_RUN, 32'h0, 0, 0);

        // load-use and imem wait together count once
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1; imem_ready = 1'b0;
        step("lu_iwait", C_LU, 32'h0, 0, 0);
        idle_inputs();
        step("lu_iwait_after", C_RUN, 32'h0, 1, 0);

        reset = 1'b0;
        step("sat_reset", C_RST, 32'h0, 1, 0);
        reset = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            step("sat_iwait", C_IWAIT, 32'h0, (i < 15) ? i : 15, 0);
        imem_ready = 1'b1;
        step("sat_hold", C_RUN, 32'h0, 15, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
